// File: rtl/mat_elem_alu.sv
// mat_elem_alu: element-wise matrix ALU for ROWS x COLS matrices of DW-bit
// elements. It computes LANES elements per cycle under a start/busy/done
// handshake. The operands are captured when start is accepted, so upstream
// may change them while the block runs.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   start   request; sampled only in IDLE or DONE
//   op      00 C=A+B, 01 C=A-B, 10 C=B-A, 11 C=A+B[0] (broadcast)
//   a_flat  matrix A, row-major, element i at [i*DW +: DW]
//   b_flat  matrix B, same packing
//   c_flat  result matrix, same packing
//   busy    high while computing
//   done    one-cycle pulse when c_flat is complete
//   ovf     sticky signed-overflow flag for the last operation
//
// Optional feature: define MAT_ELEM_ALU_SAT_EN for signed saturating
// arithmetic with an ovf flag. Without it, results wrap modulo 2^DW and ovf
// is tied to 0.
module mat_elem_alu #(
  parameter int unsigned ROWS  = 3,
  parameter int unsigned COLS  = 3,
  parameter int unsigned DW    = 32,
  parameter int unsigned LANES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [ROWS*COLS*DW-1:0]  a_flat,
  input  logic [ROWS*COLS*DW-1:0]  b_flat,
  output logic [ROWS*COLS*DW-1:0]  c_flat,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned NB = N * DW;
  localparam int unsigned IW = $clog2(N + LANES);
  localparam int unsigned SW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NB-1:0]     a_q, b_q;
  logic [1:0]        op_q;
  logic [IW-1:0]     idx_q;
  logic              capture, step, last_grp;
  logic              busy_d, done_d;

  int unsigned       lane_idx  [LANES];
  logic [SW-1:0]     lane_base [LANES];
  logic [DW-1:0]     lane_res  [LANES];
  logic [LANES-1:0]  lane_act;

  // The final group is the one whose lanes reach element N-1.
  assign last_grp = (32'(idx_q) + LANES) >= N;

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_grp) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs. busy and done follow the state that is being entered.
  always_comb begin
    capture = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE:    capture = start;
      RUN:     step    = 1'b1;
      DONE:    capture = start;
      default: ;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

`ifdef MAT_ELEM_ALU_SAT_EN
  logic [LANES-1:0] lane_ovf;

  // Compute one element with one sign-extension bit. Bit DW of the return
  // value reports a clamp.
  function automatic logic [DW:0] elem_op(input logic [1:0] o,
                                          input logic [DW-1:0] x,
                                          input logic [DW-1:0] y,
                                          input logic [DW-1:0] s);
    logic [DW:0] xe, ye, se, r;
    xe = {x[DW-1], x};
    ye = {y[DW-1], y};
    se = {s[DW-1], s};
    case (o)
      2'b00:   r = xe + ye;
      2'b01:   r = xe - ye;
      2'b10:   r = ye - xe;
      default: r = xe + se;
    endcase
    // The result overflowed if the top two bits of the extended value differ.
    // Clamp toward the sign of the true result.
    if (r[DW] != r[DW-1]) return {1'b1, r[DW], {(DW-1){~r[DW]}}};
    return {1'b0, r[DW-1:0]};
  endfunction
`else
  function automatic logic [DW-1:0] elem_op(input logic [1:0] o,
                                            input logic [DW-1:0] x,
                                            input logic [DW-1:0] y,
                                            input logic [DW-1:0] s);
    case (o)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return y - x;
      default: return x + s;
    endcase
  endfunction
`endif

  // Per-lane element selection and arithmetic. Lanes beyond element N-1 in
  // the final group are marked inactive.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_idx[l]  = 32'(idx_q) + l;
      lane_base[l] = SW'(lane_idx[l] * DW);
      lane_act[l]  = lane_idx[l] < N;
`ifdef MAT_ELEM_ALU_SAT_EN
      {lane_ovf[l], lane_res[l]} = elem_op(op_q, a_q[lane_base[l] +: DW],
                                           b_q[lane_base[l] +: DW], b_q[DW-1:0]);
`else
      lane_res[l] = elem_op(op_q, a_q[lane_base[l] +: DW],
                            b_q[lane_base[l] +: DW], b_q[DW-1:0]);
`endif
    end
  end

  // Operand capture, group index and result writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      idx_q  <= '0;
      c_flat <= '0;
    end else if (capture) begin
      a_q   <= a_flat;
      b_q   <= b_flat;
      op_q  <= op;
      idx_q <= '0;
    end else if (step) begin
      idx_q <= idx_q + IW'(LANES);
      for (int unsigned l = 0; l < LANES; l++) begin
        if (lane_act[l]) c_flat[lane_base[l] +: DW] <= lane_res[l];
      end
    end
  end

`ifdef MAT_ELEM_ALU_SAT_EN
  // Sticky until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (capture) begin
      ovf <= 1'b0;
    end else if (step && |(lane_ovf & lane_act)) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mat_elem_alu.sv
// Self-checking bench for mat_elem_alu. Two 3x3 DW=32 instances (LANES=1 and
// LANES=4) share the operand inputs and are checked against an integer
// reference model of the element-wise operations.
module tb_mat_elem_alu;

  localparam int N = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            start1, start4;
  logic [1:0]      op;
  logic [31:0]     a_e [N];
  logic [31:0]     b_e [N];
  logic [N*32-1:0] a_flat, b_flat, c1, c4;
  logic [31:0]     c1_e [N];
  logic [31:0]     c4_e [N];
  logic            busy1, busy4, done1, done4, ovf1, ovf4;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_c [2][N];
  logic        exp_ovf [2];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_flat[i*32 +: 32] = a_e[i];
      b_flat[i*32 +: 32] = b_e[i];
      c1_e[i] = c1[i*32 +: 32];
      c4_e[i] = c4[i*32 +: 32];
    end
  end

  mat_elem_alu #(.ROWS(3), .COLS(3), .DW(32), .LANES(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .op(op),
    .a_flat(a_flat), .b_flat(b_flat), .c_flat(c1),
    .busy(busy1), .done(done1), .ovf(ovf1)
  );

  mat_elem_alu #(.ROWS(3), .COLS(3), .DW(32), .LANES(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .op(op),
    .a_flat(a_flat), .b_flat(b_flat), .c_flat(c4),
    .busy(busy4), .done(done4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed arithmetic. The result is either wrapped to
  // 32 bits or clamped. Bit 32 of the return value is the overflow flag.
  function automatic logic [32:0] ref_elem(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] s);
    longint x, y, z, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    z = longint'($signed(s));
    case (o)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = y - x;
      default: r = x + z;
    endcase
`ifdef MAT_ELEM_ALU_SAT_EN
    if (r > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
    return {1'b0, r[31:0]};
  endfunction

  task automatic compute_expected(input int k);
    logic [32:0] v;
    exp_ovf[k] = 1'b0;
    for (int i = 0; i < N; i++) begin
      v = ref_elem(op, a_e[i], b_e[i], b_e[0]);
      exp_c[k][i] = v[31:0];
      exp_ovf[k] = exp_ovf[k] | v[32];
    end
  endtask

  function automatic logic busy_of(input int k);  return (k != 0) ? busy4 : busy1; endfunction
  function automatic logic done_of(input int k);  return (k != 0) ? done4 : done1; endfunction
  function automatic logic ovf_of(input int k);   return (k != 0) ? ovf4  : ovf1;  endfunction
  function automatic logic [31:0] c_of(input int k, input int i);
    return (k != 0) ? c4_e[i] : c1_e[i];
  endfunction

  task automatic set_start(input int k, input logic v);
    if (k != 0) start4 = v; else start1 = v;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic load_rand();
    for (int i = 0; i < N; i++) begin
      a_e[i] = rnd_val();
      b_e[i] = rnd_val();
    end
    op = 2'($urandom_range(0, 3));
  endtask

  task automatic load_seq(input logic [1:0] o);
    for (int i = 0; i < N; i++) begin
      a_e[i] = 32'(i + 1);
      b_e[i] = 32'(9 - i);
    end
    op = o;
  endtask

  task automatic load_const(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < N; i++) begin
      a_e[i] = a;
      b_e[i] = b;
    end
    op = o;
  endtask

  // Called at a negedge with the operands set up. It runs one operation on
  // instance k and checks the handshake timing and the result. In the
  // perturbed form, it scrambles the inputs and pulses start during RUN. With
  // b2b set, it returns at the done cycle so the caller can start again.
  task automatic run(input int k, input bit perturb, input bit b2b);
    int g;
    int cyc;
    bit seen;
    g = (k != 0) ? 3 : 9;
    cyc = 0;
    seen = 1'b0;
    compute_expected(k);
    set_start(k, 1'b1);
    @(posedge clk);
    #1;
    set_start(k, 1'b0);
    if (perturb) load_rand();
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      check("busy_done_excl", 64'(busy_of(k) & done_of(k)), 64'd0);
      if (done_of(k)) seen = 1'b1;
      else if (busy_of(k)) cyc++;
      set_start(k, (perturb && cyc == 1 && !seen) ? 1'b1 : 1'b0);
    end
    check("done_seen", 64'(seen), 64'd1);
    check("busy_cycles", 64'(cyc), 64'(g));
    for (int i = 0; i < N; i++) check($sformatf("c%0d_elem%0d", k, i), 64'(c_of(k, i)), 64'(exp_c[k][i]));
    check("ovf", 64'(ovf_of(k)), 64'(exp_ovf[k]));
    if (!b2b) begin
      @(negedge clk);
      check("done_single", 64'(done_of(k)), 64'd0);
      check("busy_after", 64'(busy_of(k)), 64'd0);
    end
  endtask

  task automatic reset_mid();
    logic [31:0] old_c [N];
    bit saw_done;
    for (int i = 0; i < N; i++) old_c[i] = exp_c[0][i];
    for (int i = 0; i < N; i++) begin
      a_e[i] = $urandom;
      b_e[i] = $urandom;
    end
    op = 2'd0;
    compute_expected(0);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_busy", 64'(busy1), 64'd1);
    for (int i = 0; i < N; i++)
      check($sformatf("mid_elem%0d", i), 64'(c1_e[i]), 64'((i < 4) ? exp_c[0][i] : old_c[i]));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_ovf", 64'(ovf1), 64'd0);
    check("rst_c1", 64'(c1 != '0), 64'd0);
    check("rst_c4", 64'(c4 != '0), 64'd0);
    saw_done = 1'b0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      saw_done = saw_done | done1 | busy1;
    end
    check("no_activity_after_reset", 64'(saw_done), 64'd0);
    for (int i = 0; i < N; i++) begin
      exp_c[0][i] = 32'd0;
      exp_c[1][i] = 32'd0;
    end
    load_seq(2'd2);
    run(0, 1'b0, 1'b0);
    check("op10_elem0", 64'(c1_e[0]), 64'h0000_0008);
    check("op10_elem8", 64'(c1_e[8]), 64'hFFFF_FFF8);
  endtask

  initial begin
    reset = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    load_const(2'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'({busy1, busy4}), 64'd0);
    check("reset_done", 64'({done1, done4}), 64'd0);
    check("reset_ovf", 64'({ovf1, ovf4}), 64'd0);
    check("reset_c", 64'((c1 != '0) || (c4 != '0)), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    load_seq(2'd0);
    run(0, 1'b0, 1'b0);
    check("add_const", 64'(c1_e[5]), 64'd10);
    run(1, 1'b0, 1'b0);
    check("add_const4", 64'(c4_e[8]), 64'd10);

    load_const(2'd1, 32'd0, 32'd1);
    run(0, 1'b0, 1'b0);
    check("sub_wrap", 64'(c1_e[3]), 64'hFFFF_FFFF);
    run(1, 1'b0, 1'b0);

    load_const(2'd1, 32'h8000_0000, 32'd1);
    run(1, 1'b0, 1'b0);
    load_const(2'd0, 32'h7FFF_FFFF, 32'd1);
    run(0, 1'b0, 1'b0);

    load_seq(2'd3);
    b_e[0] = 32'd100;
    for (int i = 1; i < N; i++) b_e[i] = 32'h0000_DEAD;
    run(1, 1'b0, 1'b0);
    check("bcast_elem8", 64'(c4_e[8]), 64'd109);
    run(0, 1'b0, 1'b0);
    check("bcast_elem0", 64'(c1_e[0]), 64'd101);

    load_seq(2'd0);
    run(0, 1'b1, 1'b0);
    load_seq(2'd1);
    run(1, 1'b1, 1'b0);

    load_rand();
    run(1, 1'b0, 1'b1);
    load_rand();
    run(1, 1'b0, 1'b1);
    load_rand();
    run(1, 1'b0, 1'b0);

    for (int it = 0; it < 12; it++) begin
      load_rand();
      run(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
